// File: rtl/stack_param.sv
// Parametrised LIFO stack with replace-top push+pop, synchronous flush, almost-full watermark
// and sticky overflow/underflow flags. Popped data is registered.
module stack_param #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             ovf_set, udf_set;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] top_word;
    logic             is_full, is_empty;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // Read port always addresses the current top entry; only meaningful when not empty.
    assign rd_addr  = AW'(count_q - CW'(1));
    assign top_word = mem[rd_addr];

    always_comb begin
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_set     = 1'b0;
        udf_set     = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = AW'(count_q);

        if (flush) begin
            count_d = '0;
        end else if (push && pop) begin
            pop_valid_d = 1'b1;
            if (is_empty) begin
                // Pass-through: nothing is stored.
                pop_data_d = wdata;
            end else begin
                pop_data_d = top_word;
                mem_we     = 1'b1;
                mem_waddr  = rd_addr;
            end
        end else if (push) begin
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                mem_we  = 1'b1;
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                udf_set = 1'b1;
            end else begin
                pop_data_d  = top_word;
                pop_valid_d = 1'b1;
                count_d     = count_q - CW'(1);
            end
        end

        // A set on the same edge beats clr_err.
        overflow_d  = ovf_set | (overflow_q & ~clr_err);
        underflow_d = udf_set | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally not reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wdata;
        end
    end

    assign pop_data    = pop_data_q;
    assign pop_valid   = pop_valid_q;
    assign count       = count_q;
    assign full        = is_full;
    assign empty       = is_empty;
    assign almost_full = (count_q >= CW'(AF_THRESH));
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign top         = is_empty ? '0 : top_word;

endmodule

// File: tb/tb_stack_param.sv
// Bench for stack_param: directed scenarios then random traffic, checked against a
// queue-based reference model.
module tb_stack_param;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned AF_THRESH = 3;
    localparam int unsigned CW        = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             push, pop, flush, clr_err;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             full, empty, almost_full, overflow, underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_pd;
    logic             m_pv, m_ovf, m_udf;

    stack_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF_THRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .clr_err    (clr_err),
        .wdata      (wdata),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .top        (top),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pd  = '0;
        m_pv  = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = mq.size();
        chk({ctx, ".count"}, 32'(count), 32'(n));
        chk({ctx, ".top"}, 32'(top), (n == 0) ? 32'd0 : 32'(mq[n-1]));
        chk({ctx, ".empty"}, 32'(empty), 32'(n == 0));
        chk({ctx, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({ctx, ".almost_full"}, 32'(almost_full), 32'(n >= AF_THRESH));
        chk({ctx, ".pop_valid"}, 32'(pop_valid), 32'(m_pv));
        chk({ctx, ".pop_data"}, 32'(pop_data), 32'(m_pd));
        chk({ctx, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({ctx, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input string ctx, input logic p, input logic q, input logic f,
                        input logic c, input logic [WIDTH-1:0] d);
        logic ovs, uds;
        push    = p;
        pop     = q;
        flush   = f;
        clr_err = c;
        wdata   = d;
        ovs     = 1'b0;
        uds     = 1'b0;
        m_pv    = 1'b0;
        if (f) begin
            mq.delete();
        end else if (p && q) begin
            m_pv = 1'b1;
            if (mq.size() == 0) begin
                m_pd = d;
            end else begin
                m_pd = mq.pop_back();
                mq.push_back(d);
            end
        end else if (p) begin
            if (mq.size() == DEPTH) ovs = 1'b1;
            else mq.push_back(d);
        end else if (q) begin
            if (mq.size() == 0) begin
                uds = 1'b1;
            end else begin
                m_pd = mq.pop_back();
                m_pv = 1'b1;
            end
        end
        m_ovf = ovs | (m_ovf & ~c);
        m_udf = uds | (m_udf & ~c);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    initial begin
        rst = 1'b1; push = 0; pop = 0; flush = 0; clr_err = 0; wdata = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Push three, check watermark
        step("push11", 1, 0, 0, 0, 8'h11);
        step("push22", 1, 0, 0, 0, 8'h22);
        step("push33", 1, 0, 0, 0, 8'h33);
        chk("top_after_3", 32'(top), 32'h33);
        chk("af_after_3", 32'(almost_full), 32'd1);

        // Three back-to-back pops
        step("pop1", 0, 1, 0, 0, 8'h00);
        chk("pop1_data", 32'(pop_data), 32'h33);
        step("pop2", 0, 1, 0, 0, 8'h00);
        chk("pop2_data", 32'(pop_data), 32'h22);
        step("pop3", 0, 1, 0, 0, 8'h00);
        chk("pop3_data", 32'(pop_data), 32'h11);
        step("idle1", 0, 0, 0, 0, 8'h00);

        // Underflow and clear semantics
        step("pop_empty", 0, 1, 0, 0, 8'h00);
        chk("udf_set", 32'(underflow), 32'd1);
        step("clr", 0, 0, 0, 1, 8'h00);
        chk("udf_clr", 32'(underflow), 32'd0);
        step("pop_empty_clr", 0, 1, 0, 1, 8'h00);
        chk("udf_set_wins", 32'(underflow), 32'd1);
        step("clr2", 0, 0, 0, 1, 8'h00);

        // Fill, overflow, replace-top while full
        for (int i = 0; i < 4; i++) step("fill", 1, 0, 0, 0, 8'hA0 + 8'(i));
        step("push_full", 1, 0, 0, 0, 8'hFF);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_top", 32'(top), 32'hA3);
        step("clr3", 0, 0, 0, 1, 8'h00);
        step("replace_full", 1, 1, 0, 0, 8'h55);
        chk("replace_pd", 32'(pop_data), 32'hA3);
        chk("replace_top", 32'(top), 32'h55);
        chk("replace_noovf", 32'(overflow), 32'd0);

        // Drain, then pass-through on empty
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 0, 0, 8'h00);
        step("passthru", 1, 1, 0, 0, 8'h77);
        chk("passthru_pd", 32'(pop_data), 32'h77);
        chk("passthru_cnt", 32'(count), 32'd0);

        // Flush beats push; flags untouched
        step("pop_empty2", 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step("fill3", 1, 0, 0, 0, 8'hC0 + 8'(i));
        step("flush_push", 1, 0, 1, 0, 8'hEE);
        chk("flush_udf_kept", 32'(underflow), 32'd1);

        // Async reset mid-stream, no clock edge
        step("pre_rst_a", 1, 0, 0, 0, 8'h01);
        step("pre_rst_b", 1, 1, 0, 0, 8'h02);
        step("pre_rst_c", 1, 0, 0, 0, 8'h03);
        push = 1'b1; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        push = 1'b0;
        rst  = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0),
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stack_param.md
Name: stack_param

Overview:
- Parametrised successor to the fixed 32x1024 PUSH/POP stack used by the CPU datapath.
- LIFO storage with configurable width and depth.
- Supports simultaneous push+pop (replace-top), a synchronous flush, an almost-full watermark, occupancy count, and sticky overflow/underflow error flags.
- Single posedge clock domain; popped data is registered for direct use by the EX/DM pipeline stage.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 1024, number of entries (>=2; need not be a power of two).
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- CW (localparam), $clog2(DEPTH+1), width of the count/pointer.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  push wdata this cycle.
- pop  input  1  pop top entry this cycle.
- flush  input  1  synchronous empty of the stack.
- clr_err  input  1  clear sticky error flags.
- wdata  input  WIDTH  data to push.
- pop_data  output  WIDTH  registered data of the last successful pop.
- pop_valid  output  1  one-cycle pulse: pop_data updated by the previous edge.
- top  output  WIDTH  combinational mem[count-1]; 0 when empty.
- count  output  CW  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- overflow  output  1  sticky: push was dropped.
- underflow  output  1  sticky: pop was attempted while empty.

Behaviour:
- Reset (async, rst=1): count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0. Memory contents are not reset. Outputs are therefore empty=1, full=0, almost_full=0 (unless AF_THRESH==0, which is illegal), top=0.
- Per-edge priority: flush > (push&pop) > push > pop.
- flush=1: count<=0, pop_valid<=0. Push/pop ignored; no error flags set. pop_data holds its value.
- push only, !full: mem[count]<=wdata; count<=count+1; pop_valid<=0.
- push only, full: write dropped; count unchanged; overflow<=1.
- pop only, !empty: pop_data<=mem[count-1]; count<=count-1; pop_valid<=1.
- pop only, empty: count unchanged; pop_valid<=0; pop_data holds; underflow<=1.
- push&pop, !empty (including full): replace-top.
  - pop_data<=mem[count-1]; mem[count-1]<=wdata; count unchanged; pop_valid<=1.
  - No overflow when full.
- push&pop, empty: pass-through.
  - pop_data<=wdata; pop_valid<=1; count stays 0; nothing stored; no flags.
- Idle (no push/pop/flush): pop_valid<=0; all else holds.
- pop_valid is a single-cycle pulse; back-to-back pops give consecutive pulses.
- Read latency: one clock from a pop edge to pop_data/pop_valid.
- top is read-during-write old-value free: it reflects the post-edge count and contents.
- Sticky flags:
  - Set conditions are evaluated each edge.
  - clr_err=1 clears both flags unless the same edge sets one; set wins.
  - Flags are cleared only by clr_err or rst.
- Arithmetic: count never wraps; all increments and decrements are guarded by full/empty.
- rst asserted mid-operation aborts any in-flight push/pop. Memory may retain the written word, but count=0 makes it unreachable.
- Memory is inferred as simple dual-port RAM on posedge: one write port, one read port at index count-1.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 (WIDTH=8, DEPTH=4, AF_THRESH=3) -> count=3, top=0x33, almost_full=1, full=0, empty=0.
- Pop x3 on consecutive cycles -> pop_data=0x33, 0x22, 0x11, each with a one-cycle pop_valid; then empty=1, top=0, underflow=0.
- Pop while empty -> underflow=1, pop_valid=0, count=0. Assert clr_err with no pop -> underflow=0. Pop with clr_err the same cycle -> underflow stays 1.
- Fill to 4 entries (0xA0..0xA3), then push 0xFF -> overflow=1, count=4, top=0xA3. Push&pop 0x55 while full -> pop_data=0xA3, top=0x55, count=4, no new flag.
- Push&pop 0x77 while empty -> pop_data=0x77, pop_valid=1, count=0, empty=1.
- With 3 entries, assert flush together with push -> count=0, pop_valid=0, flags unchanged. Assert rst mid-stream with 2 entries -> count=0, pop_data=0, pop_valid=0, flags=0 immediately (async, no clock edge).
